// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA digit controller: digit geometry,
// commit FSM encoding, default blank code and the blink masking helper.
package vga_ctrl_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIGIT_W    = 4;

   localparam logic [DIGIT_W-1:0] BLANK_CODE_DEF = 4'hF;

   typedef enum logic {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } state_e;

   typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

   // Replace every masked digit with the blank code while the blink phase is high.
   function automatic digits_t mask_digits(input digits_t live,
                                           input logic phase,
                                           input logic [NUM_DIGITS-1:0] mask,
                                           input logic [DIGIT_W-1:0] code);
      digits_t r;
      r = live;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (phase && mask[k]) begin
            r[k] = code;
         end else begin
            r[k] = live[k];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_vs_sync.sv
// Two-flop synchronizer for the asynchronous active-low vsync plus a
// falling-edge detector producing a one-cycle frame_start pulse.
module vga_vs_sync (
   input  logic clk,
   input  logic rst,
   input  logic vs_in,
   output logic frame_start
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   // Next values of the synchronizer chain and edge-history flop.
   always_comb begin
      sync1_d = vs_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Synchronizer and edge-history registers; idle level of vsync is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign frame_start = prev_q & ~sync2_q;

endmodule

// File: rtl/vga_digit_ctrl.sv
// Double-buffered 8-digit display controller: two arbitrated MMIO writers
// fill a shadow bank that is committed to the live digits once per frame.
// Optional blink feature enabled by defining VGA_DIGIT_BLINK_EN.
module vga_digit_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int                 BLINK_FRAMES = 30,
   parameter logic [DIGIT_W-1:0] BLANK_CODE   = BLANK_CODE_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_addr,
   input  logic [3:0] req0_data,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_addr,
   input  logic [3:0] req1_data,
   input  logic       vs_in,
   input  logic [7:0] blink_mask,
   output logic [3:0] s1,
   output logic [3:0] s2,
   output logic [3:0] s3,
   output logic [3:0] s4,
   output logic [3:0] s5,
   output logic [3:0] s6,
   output logic [3:0] s7,
   output logic [3:0] s8,
   output logic [7:0] frame_cnt,
   output logic       pending
);

   state_e     state_q, state_d;
   logic       prio_q, prio_d;
   digits_t    shadow_q, shadow_d;
   digits_t    live_q, live_d;
   digits_t    disp_q, disp_d;
   logic       dirty_q, dirty_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;

   logic       frame_start_s;
   logic       wr_en_s;
   logic [2:0] wr_addr_s;
   logic [3:0] wr_data_s;

   vga_vs_sync u_vs_sync (
      .clk         (clk),
      .rst         (rst),
      .vs_in       (vs_in),
      .frame_start (frame_start_s)
   );

   // Round-robin grant: prio_q names the requester preferred on contention.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            if (prio_q) begin
               req1_ready = 1'b1;
            end else begin
               req0_ready = 1'b1;
            end
         end else if (req0_valid) begin
            req0_ready = 1'b1;
         end else if (req1_valid) begin
            req1_ready = 1'b1;
         end else begin
            req0_ready = 1'b0;
         end
      end else begin
         req0_ready = 1'b0;
      end
   end

   // Mux the granted requester onto the single shadow write port.
   always_comb begin
      wr_en_s = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      if (req1_ready) begin
         wr_addr_s = req1_addr;
         wr_data_s = req1_data;
      end else begin
         wr_addr_s = req0_addr;
         wr_data_s = req0_data;
      end
   end

   // Commit FSM next-state, shadow writes and live-bank update.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      shadow_d    = shadow_q;
      live_d      = live_q;
      dirty_d     = dirty_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         IDLE: begin
            if (frame_start_s) begin
               state_d = COMMIT;
            end else begin
               state_d = IDLE;
            end
            // A write in the frame_start cycle lands before the commit reads shadow.
            if (wr_en_s) begin
               shadow_d[wr_addr_s] = wr_data_s;
               dirty_d             = 1'b1;
               prio_d              = req0_ready;
            end else begin
               dirty_d = dirty_q;
            end
         end
         COMMIT: begin
            state_d     = IDLE;
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (dirty_q) begin
               live_d  = shadow_q;
               dirty_d = 1'b0;
            end else begin
               live_d = live_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef VGA_DIGIT_BLINK_EN
   localparam int BLINK_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

   logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic                   phase_q, phase_d;

   // Blink phase toggles after every BLINK_FRAMES commits.
   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (state_q == COMMIT) begin
         if (blink_cnt_q == BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = {BLINK_CNT_W{1'b0}};
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
         end
      end else begin
         blink_cnt_d = blink_cnt_q;
      end
      disp_d = mask_digits(live_d, phase_d, blink_mask, BLANK_CODE);
   end

   // Blink counter and phase registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_q <= {BLINK_CNT_W{1'b0}};
         phase_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end
`else
   logic blink_unused_s;

   assign blink_unused_s = (^blink_mask) ^ (^BLANK_CODE) ^ (BLINK_FRAMES > 0);

   // Without blinking the display shows the live bank unmodified.
   always_comb begin
      disp_d = live_d;
   end
`endif

   // Controller state registers; reset discards any uncommitted shadow data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         shadow_q    <= '0;
         live_q      <= '0;
         disp_q      <= '0;
         dirty_q     <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         shadow_q    <= shadow_d;
         live_q      <= live_d;
         disp_q      <= disp_d;
         dirty_q     <= dirty_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign s1        = disp_q[0];
   assign s2        = disp_q[1];
   assign s3        = disp_q[2];
   assign s4        = disp_q[3];
   assign s5        = disp_q[4];
   assign s6        = disp_q[5];
   assign s7        = disp_q[6];
   assign s8        = disp_q[7];
   assign frame_cnt = frame_cnt_q;
   assign pending   = dirty_q;

endmodule

// File: tb/tb_vga_digit_ctrl.sv
// Randomized scoreboard bench for vga_digit_ctrl: a frame-level reference
// model predicts grants, pending and the digits shown after every commit.
module tb_vga_digit_ctrl;

   localparam int BF = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0] req0_addr, req1_addr;
   logic [3:0] req0_data, req1_data;
   logic       vs_in;
   logic [7:0] blink_mask;
   logic [3:0] s1, s2, s3, s4, s5, s6, s7, s8;
   logic [7:0] frame_cnt;
   logic       pending;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_digit_ctrl #(.BLINK_FRAMES(BF), .BLANK_CODE(4'hF)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_addr(req1_addr), .req1_data(req1_data),
      .vs_in(vs_in), .blink_mask(blink_mask),
      .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8),
      .frame_cnt(frame_cnt), .pending(pending)
   );

   logic [31:0] dut_digits;
   assign dut_digits = {s8, s7, s6, s5, s4, s3, s2, s1};

   typedef struct {
      logic [31:0] digits;
      logic [7:0]  cnt;
   } snap_t;

   snap_t exp_q[$];

   logic [3:0] m_shadow[8];
   logic [3:0] m_live[8];
   bit         m_dirty;
   bit         m_prio;
   int         m_frames;
   int         iter;
   int         commit_at;
   bit         reset_at_commit;
   logic       vs_prev;
   bit         hv[2];
   logic [2:0] ha[2];
   logic [3:0] hd[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] expected_display();
      logic [31:0] r;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = m_live[k];
`ifdef VGA_DIGIT_BLINK_EN
         if (((m_frames / BF) % 2) == 1 && blink_mask[k]) r[4*k +: 4] = 4'hF;
`endif
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) begin
         m_shadow[k] = 4'h0;
         m_live[k]   = 4'h0;
      end
      m_dirty = 1'b0;
      m_prio  = 1'b0;
      m_frames = 0;
      commit_at = -1;
      hv[0] = 1'b0;
      hv[1] = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      exp_q.delete();
   endtask

   // One clock of stimulus plus reference-model update.
   task automatic cycle_step(input logic vs, input int p0, input int p1, input int amax);
      int pk[2];
      bit g0, g1, in_commit, releasing;
      int k;
      pk[0] = p0;
      pk[1] = p1;
      @(negedge clk);
      releasing = !rst;
      if (releasing) begin
         #2 rst = 1'b1;
      end
      check("pending", 32'(pending), 32'(m_dirty));
      for (int j = 0; j < 2; j++) begin
         if (!releasing && !hv[j] && ($urandom_range(0, 99) < pk[j])) begin
            hv[j] = 1'b1;
            ha[j] = 3'($urandom_range(0, amax));
            hd[j] = 4'($urandom_range(0, 15));
         end
      end
      req0_valid = hv[0]; req0_addr = ha[0]; req0_data = hd[0];
      req1_valid = hv[1]; req1_addr = ha[1]; req1_data = hd[1];
      vs_in = vs;
      if (vs == 1'b0 && vs_prev == 1'b1) commit_at = iter + 3;
      vs_prev = vs;
      #1;
      in_commit = (iter == commit_at);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!in_commit) begin
         if (hv[0] && hv[1]) begin
            if (m_prio) g1 = 1'b1; else g0 = 1'b1;
         end else if (hv[0]) begin
            g0 = 1'b1;
         end else if (hv[1]) begin
            g1 = 1'b1;
         end
      end
      check("ready", {30'd0, req0_ready, req1_ready}, {30'd0, g0, g1});
      if (in_commit) begin
         if (reset_at_commit) begin
            reset_at_commit = 1'b0;
            #2 rst = 1'b0;
            #1;
            check("rst_digits", dut_digits, 32'd0);
            check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
            check("rst_pending", 32'(pending), 32'd0);
            model_reset();
         end else begin
            if (m_dirty) begin
               for (int j = 0; j < 8; j++) m_live[j] = m_shadow[j];
               m_dirty = 1'b0;
            end
            m_frames++;
            exp_q.push_back('{digits: expected_display(), cnt: 8'(m_frames)});
         end
      end else if (g0 || g1) begin
         k = g1 ? 1 : 0;
         m_shadow[ha[k]] = hd[k];
         m_dirty = 1'b1;
         m_prio  = g0;
         hv[k]   = 1'b0;
      end
      iter++;
   endtask

   // Each frame: vsync low for three cycles, then a random high gap.
   task automatic run_frames(input int n, input int p0, input int p1, input int amax);
      for (int f = 0; f < n; f++) begin
         repeat (3) cycle_step(1'b0, p0, p1, amax);
         repeat ($urandom_range(6, 14)) cycle_step(1'b1, p0, p1, amax);
      end
   endtask

   // Scoreboard monitor: pops an expectation whenever frame_cnt advances.
   initial begin
      logic [31:0] cur_exp;
      logic [7:0]  last_cnt;
      snap_t       s;
      cur_exp  = 32'd0;
      last_cnt = 8'd0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cur_exp  = 32'd0;
            last_cnt = 8'd0;
         end else if (frame_cnt != last_cnt) begin
            if (exp_q.size() == 0) begin
               check("spurious_commit", 32'(frame_cnt), 32'(last_cnt));
            end else begin
               s = exp_q.pop_front();
               check("commit_digits", dut_digits, s.digits);
               check("commit_frame_cnt", 32'(frame_cnt), 32'(s.cnt));
               cur_exp = s.digits;
            end
            last_cnt = frame_cnt;
         end else begin
            check("steady_digits", dut_digits, cur_exp);
         end
      end
   end

   initial begin
      rst = 1'b0;
      req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 4'd0;
      req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 4'd0;
      vs_in = 1'b1;
      vs_prev = 1'b1;
      blink_mask = 8'($urandom_range(0, 255));
      iter = 0;
      reset_at_commit = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_digits", dut_digits, 32'd0);
      check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
      check("reset_pending", 32'(pending), 32'd0);
      #2 rst = 1'b1;
      repeat (4) cycle_step(1'b1, 0, 0, 7);
      run_frames(3, 0, 0, 7);
      run_frames(12, 40, 40, 7);
      run_frames(3, 100, 100, 0);
      run_frames(6, 70, 20, 7);
      reset_at_commit = 1'b1;
      run_frames(1, 100, 100, 7);
      run_frames(2, 0, 0, 7);
      run_frames(4, 50, 50, 7);
      repeat (6) cycle_step(1'b1, 0, 0, 7);
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
